fabric_port_out_mvc: RTL and testbench

Single-clock NoC-to-fabric egress port.
- Accepts NoC flits on NUM_VC virtual channels and buffers each VC separately.
- Reassembles variable-length packets of 1..MAX_FLITS flits, head to tail.
- Presents whole packets to the RTL side on a valid/ready interface, choosing among VCs round-robin.
- Returns one credit per flit drained and flags protocol violations.

---
 rtl/fabric_port_out_mvc_pkg.sv | 44 ++++
 rtl/fabric_port_out_mvc_if.sv | 48 ++++
 rtl/fabric_port_out_mvc_fifo.sv | 73 +++++++
 rtl/fabric_port_out_mvc.sv | 223 ++++++++++++++++++++++
 tb/tb_fabric_port_out_mvc.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/fabric_port_out_mvc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fabric_port_pkg
// Description : Shared definitions for the NoC-to-fabric egress port:
//               flit control-bit positions, VC-field extraction helper and
//               the packet-assembly FSM state encoding.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package fabric_port_pkg;

  // Control-bit positions, expressed as distance below the flit MSB so the
  // same constants work for any flit width: bit (W - VALID_POS) is valid, etc.
  localparam int VALID_POS = 1;
  localparam int HEAD_POS  = 2;
  localparam int TAIL_POS  = 3;
  localparam int VC_POS    = 4;

  // Widest flit the helper accepts; callers zero-extend into this width.
  localparam int FLIT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VALID   = 2'd2
  } state_e;

  // Extract the VC id field [width-VC_POS -: vaw] from a zero-extended flit.
  // Result is right-justified in an 8-bit value; callers truncate to vaw bits.
  function automatic logic [7:0] get_vc(input logic [FLIT_MAX_W-1:0] flit,
                                        input int width,
                                        input int vaw);
    logic [7:0] v;
    v = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < vaw) begin
        v[3'(b)] = flit[6'(width - VC_POS - vaw + 1 + b)];
      end
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fabric_port_out_mvc_if.sv
`default_nettype none
// ============================================================================
// Module      : fabric_port_out_mvc_if
// Description : Bundle of the NoC input, credit return and RTL-side packet
//               handshake signals of the egress port.
// Ports       : noc_flit_in      - incoming flit (valid/head/tail/vc/payload)
//               noc_credits_out  - one-cycle credit pulse per VC
//               rtl_packet_out   - assembled packet, flit k in slot k
//               rtl_length_out   - flits held in the packet
//               rtl_vc_out       - source VC of the packet
//               rtl_valid_out    - packet valid
//               rtl_ready_in     - consumer ready
//               rtl_error_out    - sticky {length violation, overflow}
//               modport slave  : the egress port itself
//               modport master : the NoC sender / RTL consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface fabric_port_out_mvc_if #(
  parameter int WIDTH_NOC = 8,
  parameter int NUM_VC    = 2,
  parameter int MAX_FLITS = 4
);
  localparam int VC_ADDRESS_WIDTH = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int LEN_WIDTH        = $clog2(MAX_FLITS + 1);

  logic [WIDTH_NOC-1:0]           noc_flit_in;
  logic [NUM_VC-1:0]              noc_credits_out;
  logic [MAX_FLITS*WIDTH_NOC-1:0] rtl_packet_out;
  logic [LEN_WIDTH-1:0]           rtl_length_out;
  logic [VC_ADDRESS_WIDTH-1:0]    rtl_vc_out;
  logic                           rtl_valid_out;
  logic                           rtl_ready_in;
  logic [1:0]                     rtl_error_out;

  modport slave (
    input  noc_flit_in, rtl_ready_in,
    output noc_credits_out, rtl_packet_out, rtl_length_out,
           rtl_vc_out, rtl_valid_out, rtl_error_out
  );

  modport master (
    output noc_flit_in, rtl_ready_in,
    input  noc_credits_out, rtl_packet_out, rtl_length_out,
           rtl_vc_out, rtl_valid_out, rtl_error_out
  );

endinterface
`default_nettype wire

// File: rtl/fabric_port_out_mvc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : vc_flit_fifo
// Description : Per-VC flit buffer, registered storage, first-word-fall-
//               through (dout always shows the oldest entry).
// Ports       : clk, rst         - clock, async active-high reset
//               push / din       - write; accepted when not full or popping
//               pop  / dout      - read; ignored when empty
//               full, empty      - status flags
//               count            - number of stored flits
// Revision    : 1.0 - initial release
// ============================================================================
module vc_flit_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  wire logic                       clk,
  input  wire logic                       rst,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [WIDTH-1:0]           din,
  output logic      [WIDTH-1:0]           dout,
  output logic                            full,
  output logic                            empty,
  output logic      [$clog2(DEPTH+1)-1:0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && !empty;
  // A full FIFO still takes a write when the same edge frees a slot.
  assign w_do_push = push && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr] <= din;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) begin
        r_wr <= (r_wr == AW'(DEPTH - 1)) ? '0 : r_wr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd <= (r_rd == AW'(DEPTH - 1)) ? '0 : r_rd + 1'b1;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rd];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/fabric_port_out_mvc.sv
`default_nettype none
// ============================================================================
// Module      : fabric_port_out_mvc
// Description : NoC-to-fabric egress port. Buffers flits per VC, reassembles
//               whole packets, presents them round-robin across VCs on a
//               valid/ready interface and returns one credit per flit popped.
// Ports       : clk  - port clock
//               rst  - asynchronous active-high reset
//               bus  - fabric_port_out_mvc_if.slave (flit in, credits out,
//                      packet/length/vc/valid out, ready in, sticky errors)
// Revision    : 1.0 - initial release
// ============================================================================
module fabric_port_out_mvc
  import fabric_port_pkg::*;
#(
  parameter int WIDTH_NOC    = 8,
  parameter int NUM_VC       = 2,
  parameter int DEPTH_PER_VC = 8,
  parameter int MAX_FLITS    = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  fabric_port_out_mvc_if.slave   bus
);
  localparam int VAW       = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int LEN_WIDTH = $clog2(MAX_FLITS + 1);
  localparam int CW        = $clog2(DEPTH_PER_VC + 1);
  // Input counter saturates at MAX_FLITS+1, enough to flag every extra flit.
  localparam int IW        = $clog2(MAX_FLITS + 2);

  logic [WIDTH_NOC-1:0] w_flit;
  logic                 w_valid;
  logic                 w_tail;
  logic [VAW-1:0]       w_vc;
  logic                 w_vc_ok;

  logic [NUM_VC-1:0]    w_push;
  logic [NUM_VC-1:0]    w_pop;
  logic [NUM_VC-1:0]    w_full;
  logic [NUM_VC-1:0]    w_empty;
  logic [NUM_VC-1:0]    w_space;
  logic [NUM_VC-1:0]    w_tail_in;
  logic [NUM_VC-1:0]    w_tail_out;
  logic [NUM_VC-1:0]    w_len_viol;
  logic [WIDTH_NOC-1:0] w_dout [NUM_VC];
  logic [CW-1:0]        w_cnt  [NUM_VC];

  logic [CW-1:0]        r_pkt_cnt [NUM_VC];
  logic [IW-1:0]        r_in_cnt  [NUM_VC];

  state_e               r_state;
  logic [VAW-1:0]       r_rr;
  logic [VAW-1:0]       r_grant;
  logic [LEN_WIDTH-1:0] r_idx;
  logic [WIDTH_NOC-1:0] r_slot [MAX_FLITS];
  logic                 r_valid;
  logic [LEN_WIDTH-1:0] r_len;
  logic [VAW-1:0]       r_vc;
  logic [NUM_VC-1:0]    r_credit;
  logic [1:0]           r_err;

  logic                 w_any;
  logic [VAW-1:0]       w_gnt;
  logic                 w_ovf;
  logic                 w_cur_pop;
  logic [WIDTH_NOC-1:0] w_cur;

  assign w_flit  = bus.noc_flit_in;
  assign w_valid = w_flit[WIDTH_NOC-VALID_POS];
  assign w_tail  = w_flit[WIDTH_NOC-TAIL_POS];
  assign w_vc    = VAW'(get_vc((FLIT_MAX_W)'(w_flit), WIDTH_NOC, VAW));
  assign w_vc_ok = (32'(w_vc) < NUM_VC);

  generate
    for (genvar i = 0; i < NUM_VC; i++) begin : g_vc
      assign w_pop[i]      = (r_state == COLLECT) && (r_grant == VAW'(i)) && !w_empty[i];
      assign w_space[i]    = (w_cnt[i] != CW'(DEPTH_PER_VC));
      assign w_push[i]     = w_valid && (w_vc == VAW'(i)) && (w_space[i] || w_pop[i]);
      assign w_tail_in[i]  = w_push[i] && w_tail;
      assign w_tail_out[i] = w_pop[i] && w_dout[i][WIDTH_NOC-TAIL_POS];
      assign w_len_viol[i] = w_push[i] && (r_in_cnt[i] >= IW'(MAX_FLITS));

      vc_flit_fifo #(
        .WIDTH (WIDTH_NOC),
        .DEPTH (DEPTH_PER_VC)
      ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push[i]),
        .pop   (w_pop[i]),
        .din   (w_flit),
        .dout  (w_dout[i]),
        .full  (w_full[i]),
        .empty (w_empty[i]),
        .count (w_cnt[i])
      );
    end
  endgenerate

  // Drop: write targets a full FIFO that is not popping on this edge.
  assign w_ovf     = w_valid && w_vc_ok && w_full[w_vc] && !w_pop[w_vc];
  assign w_cur_pop = |w_pop;
  assign w_cur     = w_dout[r_grant];

  // First VC with a complete packet, searching from the round-robin pointer.
  // Scanned from the far end so the nearest candidate wins.
  always_comb begin
    logic [VAW-1:0] w_idx;
    w_any = 1'b0;
    w_gnt = r_rr;
    w_idx = '0;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      w_idx = VAW'((32'(r_rr) + k) % NUM_VC);
      if (r_pkt_cnt[w_idx] != '0) begin
        w_any = 1'b1;
        w_gnt = w_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_VC; i++) begin
        r_pkt_cnt[i] <= '0;
        r_in_cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_VC; i++) begin
        case ({w_tail_in[i], w_tail_out[i]})
          2'b10:   r_pkt_cnt[i] <= r_pkt_cnt[i] + 1'b1;
          2'b01:   r_pkt_cnt[i] <= r_pkt_cnt[i] - 1'b1;
          default: r_pkt_cnt[i] <= r_pkt_cnt[i];
        endcase
        if (w_push[i]) begin
          if (w_tail) begin
            r_in_cnt[i] <= '0;
          end else if (r_in_cnt[i] != IW'(MAX_FLITS + 1)) begin
            r_in_cnt[i] <= r_in_cnt[i] + 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_rr     <= '0;
      r_grant  <= '0;
      r_idx    <= '0;
      r_valid  <= 1'b0;
      r_len    <= '0;
      r_vc     <= '0;
      r_credit <= '0;
      r_err    <= '0;
      for (int s = 0; s < MAX_FLITS; s++) begin
        r_slot[s] <= '0;
      end
    end else begin
      r_credit <= '0;
      if (w_cur_pop) begin
        r_credit[r_grant] <= 1'b1;
      end
      r_err[0] <= r_err[0] | w_ovf;
      r_err[1] <= r_err[1] | (|w_len_viol);

      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_grant <= w_gnt;
            r_rr    <= (w_gnt == VAW'(NUM_VC - 1)) ? '0 : w_gnt + 1'b1;
            r_idx   <= '0;
            for (int s = 0; s < MAX_FLITS; s++) begin
              r_slot[s] <= '0;
            end
            r_state <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_cur_pop) begin
            // Flits beyond MAX_FLITS are popped (and credited) but not kept.
            if (r_idx < LEN_WIDTH'(MAX_FLITS)) begin
              for (int s = 0; s < MAX_FLITS; s++) begin
                if (r_idx == LEN_WIDTH'(s)) begin
                  r_slot[s] <= w_cur;
                end
              end
              r_idx <= r_idx + 1'b1;
            end
            if (w_cur[WIDTH_NOC-TAIL_POS]) begin
              r_len   <= (r_idx < LEN_WIDTH'(MAX_FLITS)) ? r_idx + 1'b1
                                                          : LEN_WIDTH'(MAX_FLITS);
              r_vc    <= r_grant;
              r_valid <= 1'b1;
              r_state <= VALID;
            end
          end
        end
        VALID: begin
          if (bus.rtl_ready_in) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  generate
    for (genvar s = 0; s < MAX_FLITS; s++) begin : g_slot
      assign bus.rtl_packet_out[s*WIDTH_NOC +: WIDTH_NOC] = r_slot[s];
    end
  endgenerate

  assign bus.noc_credits_out = r_credit;
  assign bus.rtl_length_out  = r_len;
  assign bus.rtl_vc_out      = r_vc;
  assign bus.rtl_valid_out   = r_valid;
  assign bus.rtl_error_out   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fabric_port_out_mvc.sv
`default_nettype none
// ============================================================================
// Module      : tb_fabric_port_out_mvc
// Description : Directed self-checking bench for the egress port. Flit
//               format (8 bits): {valid, head, tail, vc, payload[3:0]}.
// Ports       : none
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fabric_port_out_mvc;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fabric_port_out_mvc_if #(.WIDTH_NOC(8), .NUM_VC(2), .MAX_FLITS(4)) bus_if ();

  fabric_port_out_mvc #(
    .WIDTH_NOC    (8),
    .NUM_VC       (2),
    .DEPTH_PER_VC (8),
    .MAX_FLITS    (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q_pkt [$];
  int          q_len [$];
  int          q_vc  [$];
  int          cred0 = 0;
  int          cred1 = 0;
  int          lat;
  logic [31:0] snap_pkt;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Observe outputs on the falling edge; inputs change 2 ns after rising edges.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.noc_credits_out[0]) cred0++;
      if (bus_if.noc_credits_out[1]) cred1++;
      if (bus_if.noc_credits_out != 2'b00)
        check("credit_onehot", 64'($countones(bus_if.noc_credits_out)), 64'd1);
      if (bus_if.rtl_valid_out && bus_if.rtl_ready_in) begin
        q_pkt.push_back(bus_if.rtl_packet_out);
        q_len.push_back(int'(bus_if.rtl_length_out));
        q_vc.push_back(int'(bus_if.rtl_vc_out));
      end
    end
  end

  function automatic logic [7:0] mk(input int vc, input bit h, input bit t, input int p);
    logic [3:0] pl;
    pl = 4'(p);
    return {1'b1, h, t, vc[0], pl};
  endfunction

  task automatic send(input logic [7:0] f);
    @(posedge clk);
    #2 bus_if.noc_flit_in = f;
  endtask

  task automatic end_send();
    @(posedge clk);
    #2 bus_if.noc_flit_in = 8'h00;
  endtask

  task automatic clear_mon();
    q_pkt.delete();
    q_len.delete();
    q_vc.delete();
    cred0 = 0;
    cred1 = 0;
  endtask

  // Counts rising edges after the tail write edge until valid is seen.
  task automatic measure_lat(output int edges);
    edges = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk);
      edges++;
      #1;
      if (bus_if.rtl_valid_out) break;
    end
  endtask

  task automatic wait_pkts(input string tag, input int n, input int budget);
    for (int c = 0; c < budget && q_pkt.size() < n; c++) @(posedge clk);
    check(tag, 64'(q_pkt.size()), 64'(n));
  endtask

  initial begin
    rst = 1'b1;
    bus_if.noc_flit_in  = 8'h00;
    bus_if.rtl_ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid",   64'(bus_if.rtl_valid_out),   64'd0);
    check("rst_credits", 64'(bus_if.noc_credits_out), 64'd0);
    check("rst_packet",  64'(bus_if.rtl_packet_out),  64'd0);
    check("rst_length",  64'(bus_if.rtl_length_out),  64'd0);
    check("rst_vc",      64'(bus_if.rtl_vc_out),      64'd0);
    check("rst_error",   64'(bus_if.rtl_error_out),   64'd0);
    rst = 1'b0;

    // 1: 4-flit packet on VC0
    bus_if.rtl_ready_in = 1'b1;
    clear_mon();
    send(mk(0, 1, 0, 0)); send(mk(0, 0, 0, 1)); send(mk(0, 0, 0, 2)); send(mk(0, 0, 1, 3));
    end_send();
    measure_lat(lat);
    check("t1_latency", 64'(lat), 64'd5);
    check("t1_length",  64'(bus_if.rtl_length_out), 64'd4);
    check("t1_vc",      64'(bus_if.rtl_vc_out),     64'd0);
    check("t1_packet",  64'(bus_if.rtl_packet_out), 64'hA3_82_81_C0);
    wait_pkts("t1_delivered", 1, 20);
    repeat (3) @(posedge clk);
    check("t1_cred0", 64'(cred0), 64'd4);
    check("t1_cred1", 64'(cred1), 64'd0);

    // 2: interleaved 2-flit packets on VC0 / VC1
    clear_mon();
    send(mk(0, 1, 0, 1)); send(mk(1, 1, 0, 2)); send(mk(0, 0, 1, 3)); send(mk(1, 0, 1, 4));
    send(mk(0, 1, 0, 5)); send(mk(1, 1, 0, 6)); send(mk(0, 0, 1, 7)); send(mk(1, 0, 1, 8));
    end_send();
    wait_pkts("t2_delivered", 4, 100);
    repeat (3) @(posedge clk);
    check("t2_vc0", 64'(q_vc[0]), 64'd0);
    check("t2_vc1", 64'(q_vc[1]), 64'd1);
    check("t2_vc2", 64'(q_vc[2]), 64'd0);
    check("t2_vc3", 64'(q_vc[3]), 64'd1);
    check("t2_pkt0", 64'(q_pkt[0]), 64'h0000_A3C1);
    check("t2_pkt1", 64'(q_pkt[1]), 64'h0000_B4D2);
    check("t2_pkt3", 64'(q_pkt[3]), 64'h0000_B8D6);
    check("t2_len0", 64'(q_len[0]), 64'd2);
    check("t2_cred0", 64'(cred0), 64'd4);
    check("t2_cred1", 64'(cred1), 64'd4);

    // 3: stall, fill VC1 buffer, overflow, then drain
    clear_mon();
    bus_if.rtl_ready_in = 1'b0;
    send(mk(1, 1, 1, 9));
    end_send();
    repeat (6) @(posedge clk);
    #1;
    check("t3_stall_valid", 64'(bus_if.rtl_valid_out),  64'd1);
    check("t3_stall_pkt",   64'(bus_if.rtl_packet_out), 64'h0000_00F9);
    check("t3_stall_vc",    64'(bus_if.rtl_vc_out),     64'd1);
    snap_pkt = bus_if.rtl_packet_out;
    send(mk(1, 1, 0, 10)); send(mk(1, 0, 0, 10)); send(mk(1, 0, 0, 10)); send(mk(1, 0, 1, 10));
    send(mk(1, 1, 0, 11)); send(mk(1, 0, 0, 11)); send(mk(1, 0, 0, 11)); send(mk(1, 0, 1, 11));
    end_send();
    #1;
    check("t3_err_before", 64'(bus_if.rtl_error_out), 64'd0);
    send(mk(1, 1, 1, 12));
    end_send();
    #1;
    check("t3_err_ovf",     64'(bus_if.rtl_error_out),  64'd1);
    check("t3_hold_pkt",    64'(bus_if.rtl_packet_out), 64'(snap_pkt));
    check("t3_hold_len",    64'(bus_if.rtl_length_out), 64'd1);
    check("t3_hold_valid",  64'(bus_if.rtl_valid_out),  64'd1);
    check("t3_stall_cred1", 64'(cred1), 64'd1);
    bus_if.rtl_ready_in = 1'b1;
    wait_pkts("t3_delivered", 3, 200);
    repeat (20) @(posedge clk);
    check("t3_no_extra", 64'(q_pkt.size()), 64'd3);
    check("t3_pkt0",  64'(q_pkt[0]), 64'h0000_00F9);
    check("t3_len1",  64'(q_len[1]), 64'd4);
    check("t3_pkt2",  64'(q_pkt[2]), 64'hBB_9B_9B_DB);
    check("t3_cred1", 64'(cred1), 64'd9);

    // 4: 6-flit packet on VC0 exceeds MAX_FLITS
    clear_mon();
    send(mk(0, 1, 0, 0)); send(mk(0, 0, 0, 1)); send(mk(0, 0, 0, 2));
    send(mk(0, 0, 0, 3)); send(mk(0, 0, 0, 4)); send(mk(0, 0, 1, 5));
    end_send();
    #1;
    check("t4_err_len", 64'(bus_if.rtl_error_out), 64'd3);
    wait_pkts("t4_delivered", 1, 50);
    repeat (3) @(posedge clk);
    check("t4_len",   64'(q_len[0]), 64'd4);
    check("t4_pkt",   64'(q_pkt[0]), 64'h83_82_81_C0);
    check("t4_vc",    64'(q_vc[0]),  64'd0);
    check("t4_cred0", 64'(cred0), 64'd6);

    // 5: single-flit packet
    clear_mon();
    send(mk(0, 1, 1, 7));
    end_send();
    measure_lat(lat);
    check("t5_latency", 64'(lat), 64'd2);
    check("t5_length",  64'(bus_if.rtl_length_out), 64'd1);
    check("t5_packet",  64'(bus_if.rtl_packet_out), 64'h0000_00E7);

    // 6: reset while collecting
    repeat (3) @(posedge clk);
    clear_mon();
    send(mk(1, 1, 0, 1)); send(mk(1, 0, 0, 2)); send(mk(1, 0, 0, 3)); send(mk(1, 0, 1, 4));
    end_send();
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t6_valid",   64'(bus_if.rtl_valid_out),   64'd0);
    check("t6_credits", 64'(bus_if.noc_credits_out), 64'd0);
    check("t6_packet",  64'(bus_if.rtl_packet_out),  64'd0);
    check("t6_length",  64'(bus_if.rtl_length_out),  64'd0);
    check("t6_vc",      64'(bus_if.rtl_vc_out),      64'd0);
    check("t6_error",   64'(bus_if.rtl_error_out),   64'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    clear_mon();
    repeat (10) @(posedge clk);
    check("t6_stray_cred", 64'(cred0 + cred1), 64'd0);
    check("t6_stray_pkt",  64'(q_pkt.size()), 64'd0);
    send(mk(0, 1, 0, 13)); send(mk(0, 0, 1, 14));
    end_send();
    wait_pkts("t6_delivered", 1, 50);
    repeat (3) @(posedge clk);
    check("t6_pkt",   64'(q_pkt[0]), 64'h0000_AECD);
    check("t6_len",   64'(q_len[0]), 64'd2);
    check("t6_cred0", 64'(cred0), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
